seq_div_16x8: RTL and testbench

//  Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor ->

---
 rtl/seq_div_16x8.sv | 155 +++++++++++++++
 tb/tb_seq_div_16x8.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_16x8.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_16x8
// Purpose  : Sequential restoring divider. A 2*WIDTH-bit dividend is divided
//            by a WIDTH-bit divisor. One quotient bit is produced per clock.
//            Division by zero and quotient overflow are reported on err.
//            Only one division is in flight at a time.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            in_valid   - dividend/divisor valid
//            in_ready   - block can accept an operation (IDLE only)
//            dividend   - 2*WIDTH-bit numerator, sampled on input handshake
//            divisor    - WIDTH-bit denominator, sampled on input handshake
//            out_valid  - quot/rem/err valid
//            out_ready  - consumer accepts the result
//            quot       - WIDTH-bit quotient
//            rem        - WIDTH-bit remainder
//            err        - overflow or divide-by-zero for this result
// Revision : 1.0  initial release
// ============================================================================
module seq_div_16x8 #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   quot,
   output logic [WIDTH-1:0]   rem,
   output logic               err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
   localparam logic [CW-1:0] c_one  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_quot;
   logic [WIDTH-1:0]   r_rem;
   logic               r_err;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_p;        // partial remainder, always < divisor
   logic [WIDTH-1:0]   r_shift;    // remaining low dividend bits, MSB first
   logic [WIDTH-1:0]   r_q;        // quotient bits collected so far
   logic [WIDTH-1:0]   r_divisor;
   logic               r_ovf;      // operation flagged as overflow at accept

   logic               w_ovf;
   logic [WIDTH:0]     w_t;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_p_next;
   logic [WIDTH-1:0]   w_q_next;

   // Quotient fits in WIDTH bits only if the upper dividend half is below
   // the divisor; this comparison also catches divisor == 0.
   assign w_ovf    = (dividend[2*WIDTH-1:WIDTH] >= divisor);

   // Trial shift of the partial remainder. The difference only matters when
   // T >= divisor, and then it is smaller than the divisor, so WIDTH bits hold it.
   assign w_t      = {r_p, r_shift[WIDTH-1]};
   assign w_ge     = (w_t >= {1'b0, r_divisor});
   assign w_diff   = w_t[WIDTH-1:0] - r_divisor;
   assign w_p_next = w_ge ? w_diff : w_t[WIDTH-1:0];
   assign w_q_next = {r_q[WIDTH-2:0], w_ge};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_quot      <= '0;
         r_rem       <= '0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
         r_p         <= '0;
         r_shift     <= '0;
         r_q         <= '0;
         r_divisor   <= '0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // in_ready rises on the first edge after reset release.
               r_in_ready <= 1'b1;
               if (in_valid && r_in_ready) begin
                  r_in_ready <= 1'b0;
                  r_divisor  <= divisor;
                  r_p        <= dividend[2*WIDTH-1:WIDTH];
                  r_shift    <= dividend[WIDTH-1:0];
                  r_q        <= '0;
                  r_cnt      <= '0;
                  r_ovf      <= w_ovf;
                  r_state    <= S_CALC;
               end
            end
            S_CALC: begin
               if (r_ovf) begin
                  // Error results still take one edge so they share the
                  // registered output path of normal results.
                  r_quot      <= '1;
                  r_rem       <= '1;
                  r_err       <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_p     <= w_p_next;
                  r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                  r_q     <= w_q_next;
                  r_cnt   <= r_cnt + c_one;
                  if (r_cnt == c_last) begin
                     r_quot      <= w_q_next;
                     r_rem       <= w_p_next;
                     r_err       <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign quot      = r_quot;
   assign rem       = r_rem;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_div_16x8.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_div_16x8
// Purpose  : Directed self-checking bench for seq_div_16x8 with a short
//            randomized run checked against the / and % operators.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_div_16x8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  quot;
   logic [7:0]  rem;
   logic        err;

   int tests = 0;
   int fails = 0;

   seq_div_16x8 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quot      (quot),
      .rem       (rem),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Drives one operation and waits for its result. Returns at a negedge with
   // the result presented and out_ready low. lat counts edges after handshake.
   task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                         output int lat, output bit tmo);
      int w;
      tmo = 1'b0;
      lat = 0;
      @(negedge clk);
      dividend = dd;
      divisor  = dv;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         tmo = 1'b1;
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) tmo = 1'b1;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      tests++;
      if ({in_ready, out_valid, quot, rem, err} !== 19'd0) begin
         fails++;
         $display("FAIL reset_state: got rdy=%b vld=%b q=%0d r=%0d e=%b required all zero",
                  in_ready, out_valid, quot, rem, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL ready_before_edge: got %b required 0", in_ready);
      end
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL ready_after_edge: got %b required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      int lat;
      bit tmo;
      run_op(16'd1000, 8'd7, lat, tmo);
      tests++;
      if (tmo || lat != 8 || quot !== 8'd142 || rem !== 8'd6 || err !== 1'b0) begin
         fails++;
         $display("FAIL div_1000_7: got tmo=%b lat=%0d q=%0d r=%0d e=%b required lat=8 q=142 r=6 e=0",
                  tmo, lat, quot, rem, err);
      end
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL ready_in_done: got %b required 0", in_ready);
      end
      accept();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL accept_to_idle: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_max_quot();
      logic [15:0] dd [2] = '{16'hFE01, 16'h04FF};
      logic [7:0]  dv [2] = '{8'hFF, 8'h05};
      logic [7:0]  eq [2] = '{8'd255, 8'd255};
      logic [7:0]  er [2] = '{8'd0, 8'd4};
      int lat;
      bit tmo;
      for (int i = 0; i < 2; i++) begin
         run_op(dd[i], dv[i], lat, tmo);
         tests++;
         if (tmo || lat != 8 || quot !== eq[i] || rem !== er[i] || err !== 1'b0) begin
            fails++;
            $display("FAIL max_quot[%0d]: got tmo=%b lat=%0d q=%0d r=%0d e=%b required lat=8 q=%0d r=%0d e=0",
                     i, tmo, lat, quot, rem, err, eq[i], er[i]);
         end
         accept();
      end
   endtask

   task automatic test_errors();
      logic [15:0] dd [2] = '{16'h1234, 16'h0500};
      logic [7:0]  dv [2] = '{8'h00, 8'h05};
      int lat;
      bit tmo;
      for (int i = 0; i < 2; i++) begin
         run_op(dd[i], dv[i], lat, tmo);
         tests++;
         if (tmo || lat != 1 || quot !== 8'hFF || rem !== 8'hFF || err !== 1'b1) begin
            fails++;
            $display("FAIL error_case[%0d]: got tmo=%b lat=%0d q=%h r=%h e=%b required lat=1 q=ff r=ff e=1",
                     i, tmo, lat, quot, rem, err);
         end
         accept();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bit tmo;
      run_op(16'd5000, 8'd100, lat, tmo);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (tmo || out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== 8'd50 ||
             rem !== 8'd0 || err !== 1'b0) begin
            fails++;
            $display("FAIL hold_cycle%0d: got vld=%b rdy=%b q=%0d r=%0d e=%b required vld=1 rdy=0 q=50 r=0 e=0",
                     i, out_valid, in_ready, quot, rem, err);
         end
         @(negedge clk);
      end
      accept();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || quot !== 8'd50) begin
         fails++;
         $display("FAIL release_hold: got vld=%b rdy=%b q=%0d required vld=0 rdy=1 q=50",
                  out_valid, in_ready, quot);
      end
   endtask

   task automatic test_reset_mid_calc();
      int  lat;
      bit  tmo;
      bit  seen;
      // Reset while a result is presented: clears without waiting for an edge.
      run_op(16'd1000, 8'd7, lat, tmo);
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || quot !== 8'd0 || rem !== 8'd0 || err !== 1'b0) begin
         fails++;
         $display("FAIL async_reset_done: got vld=%b q=%0d r=%0d e=%b required all zero",
                  out_valid, quot, rem, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Reset after four division steps: the operation must be discarded.
      @(negedge clk);
      dividend = 16'd1000;
      divisor  = 8'd7;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL async_reset_calc: got vld=%b rdy=%b required 0 0", out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      tests++;
      if (seen || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL op_discarded: got stray_valid=%b rdy=%b required 0 1", seen, in_ready);
      end
      run_op(16'd100, 8'd3, lat, tmo);
      tests++;
      if (tmo || lat != 8 || quot !== 8'd33 || rem !== 8'd1 || err !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_100_3: got tmo=%b lat=%0d q=%0d r=%0d e=%b required lat=8 q=33 r=1 e=0",
                  tmo, lat, quot, rem, err);
      end
      accept();
   endtask

   task automatic test_random();
      logic [15:0] dd;
      logic [7:0]  dv;
      logic [7:0]  eq, er;
      logic        ee;
      int          el, lat;
      bit          tmo;
      for (int i = 0; i < 1500; i++) begin
         dv = 8'($urandom_range(0, 255));
         if (dv != 0 && $urandom_range(0, 3) != 0)
            dd = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom)};
         else
            dd = 16'($urandom);
         if ({8'd0, dd[15:8]} >= {8'd0, dv}) begin
            eq = 8'hFF; er = 8'hFF; ee = 1'b1; el = 1;
         end else begin
            eq = 8'(dd / {8'd0, dv});
            er = 8'(dd % {8'd0, dv});
            ee = 1'b0; el = 8;
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(dd, dv, lat, tmo);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         tests++;
         if (tmo || lat != el || quot !== eq || rem !== er || err !== ee) begin
            fails++;
            $display("FAIL random[%0d] %0d/%0d: got tmo=%b lat=%0d q=%0d r=%0d e=%b required lat=%0d q=%0d r=%0d e=%b",
                     i, dd, dv, tmo, lat, quot, rem, err, el, eq, er, ee);
         end
         accept();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max_quot();
      test_errors();
      test_backpressure();
      test_reset_mid_calc();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
